// File: rtl/alu_seq_param.sv
// Registered, handshaked ALU: add/sub/nand/nor/illegal finish in one cycle,
// multiply runs an iterative shift-add over DATA_WIDTH cycles.
module alu_seq_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic [DATA_WIDTH-1:0]     a_in,
  input  logic [DATA_WIDTH-1:0]     b_in,
  input  logic [2:0]                sel_in,
  output logic [2*DATA_WIDTH-1:0]   q_out,
  output logic                      done_out,
  output logic                      busy_out,
  output logic                      err_out
);
  localparam int W = DATA_WIDTH;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [W-1:0]       mcand_reg, mcand_next;
  // Upper half: partial product; lower half: multiplier bits still to consume.
  logic [2*W-1:0]     acc_reg, acc_next;
  logic [2*W-1:0]     q_reg, q_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic [W:0]         add_res;
  logic [W:0]         sub_res;
  logic [W:0]         partial;
  logic [2*W-1:0]     acc_shift;

  assign add_res   = {1'b0, a_in} + {1'b0, b_in};
  assign sub_res   = {1'b0, a_in} - {1'b0, b_in};
  assign partial   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});
  assign acc_shift = {partial, acc_reg[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mcand_reg <= mcand_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mcand_next = mcand_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          case (sel_in)
            3'd0: begin
              q_next    = {{(W-1){1'b0}}, add_res};
              err_next  = 1'b0;
              done_next = 1'b1;
            end
            3'd1: begin
              q_next    = {{W{sub_res[W]}}, sub_res[W-1:0]};
              err_next  = 1'b0;
              done_next = 1'b1;
            end
            3'd2: begin
              mcand_next = a_in;
              acc_next   = {{W{1'b0}}, b_in};
              cnt_next   = '0;
              state_next = MUL;
            end
            3'd3: begin
              q_next    = {{W{1'b0}}, ~(a_in & b_in)};
              err_next  = 1'b0;
              done_next = 1'b1;
            end
            3'd4: begin
              q_next    = {{W{1'b0}}, ~(a_in | b_in)};
              err_next  = 1'b0;
              done_next = 1'b1;
            end
            default: begin
              q_next    = '0;
              err_next  = 1'b1;
              done_next = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_next = acc_shift;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_WIDTH'(W - 1)) begin
          q_next     = acc_shift;
          err_next   = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign q_out    = q_reg;
  assign done_out = done_reg;
  assign err_out  = err_reg;
  assign busy_out = (state_reg == MUL);
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Registered, handshaked successor to the combinational parametrical ALU.
- Operations: add, subtract, multiply, NAND, NOR.
- Add, subtract, NAND and NOR complete in one cycle. Multiply uses an iterative shift-add datapath taking DATA_WIDTH cycles.
- Sits between the operand register file and the result bus. Provides start/busy/done control, a registered result and an illegal-opcode flag.

Parameters:
- DATA_WIDTH, 8, operand width in bits; must be >= 2.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, multiply iteration counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  request; accepted only when busy_out=0.
- a_in  input  DATA_WIDTH  operand A; sampled on the accept edge.
- b_in  input  DATA_WIDTH  operand B; sampled on the accept edge.
- sel_in  input  3  opcode: 0 add, 1 sub, 2 mul, 3 nand, 4 nor, 5-7 illegal; sampled on the accept edge.
- q_out  output  2*DATA_WIDTH  registered result.
- done_out  output  1  one-cycle pulse marking a new q_out.
- busy_out  output  1  high while a multiply is in progress.
- err_out  output  1  registered; updated with each done_out.

Behaviour:
- Reset (rst=1 at a rising edge): q_out=0, done_out=0, busy_out=0, err_out=0, state=IDLE, counter=0, internal accumulators cleared. Reset has priority over every other event, including mid-multiply; the aborted multiply produces no done_out.
- States: IDLE, MUL.
- Accept: start_in=1 and state=IDLE at a rising edge. start_in while busy_out=1 is ignored; it is not queued.
- Single-cycle ops (sel 0, 1, 3, 4, 5-7):
  - At the accept edge, q_out and err_out are written and done_out=1 for exactly the next cycle.
  - Latency 1; state stays IDLE.
  - Back-to-back starts every cycle are legal: throughput 1/cycle, done_out high continuously.
- Result formats:
  - add: {(DATA_WIDTH-1) zeros, carry, sum}.
  - sub: a-b, i.e. {DATA_WIDTH copies of borrow, diff}. Borrow=1 when a<b (unsigned).
  - nand, nor: bitwise result zero-extended to 2*DATA_WIDTH.
  - illegal (5-7): q_out=0 and err_out=1. For every legal op, err_out=0.
- Multiply (sel 2):
  - At the accept edge: latch a_in into a multiplicand register and b_in into a multiplier shift register; clear the partial-product accumulator; counter=0; state=MUL; busy_out=1 from the next cycle.
  - Each edge in MUL: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator (DATA_WIDTH+1-bit add including carry). Shift the accumulator right by 1, shift the multiplier right by 1, counter+1.
  - On the edge where the counter reaches DATA_WIDTH-1, i.e. the DATA_WIDTH-th iteration: q_out = full unsigned product, done_out=1 next cycle, err_out=0, busy_out=0, state=IDLE.
  - Total latency from accept edge to done_out high: DATA_WIDTH+1 cycles.
- start_in on the same edge that a multiply completes is ignored, because state was MUL. A new start is accepted in the first cycle that busy_out=0.
- q_out and err_out hold their value between completions. done_out is never high for more than one cycle per accepted op.
- Operand inputs may change freely after the accept edge without affecting the in-flight result.
- Product is exact for all operand values; e.g. max*max = 2^(2W) - 2^(W+1) + 1, no overflow.

Test Plan (DATA_WIDTH=4):
- Add: reset, then start with sel=0, a=9, b=8 -> next cycle done_out=1, q_out=8'h11, err_out=0.
- Sub underflow: sel=1, a=3, b=5 -> q_out=8'hFE, done_out 1 cycle later. Sub no underflow: sel=1, a=5, b=3 -> q_out=8'h02.
- Multiply timing:
  - sel=2, a=15, b=15 -> busy_out=1 for 4 cycles, done_out in cycle 5 after accept, q_out=8'hE1.
  - start_in held high with sel=0, a=1, b=1 during the busy cycles is ignored.
  - That held request is accepted on the first cycle busy_out=0; its done_out yields q_out=8'h02.
- Logic and illegal ops, back-to-back every cycle:
  - nand a=4'hC, b=4'hA -> 8'h07.
  - nor a=4'hC, b=4'hA -> 8'h01.
  - sel=6 -> q_out=8'h00, err_out=1.
  - done_out high 3 consecutive cycles.
- Reset mid-multiply: sel=2, a=7, b=6, assert rst 2 cycles after accept -> q_out=0, busy_out=0, no done_out afterwards. A new multiply a=7, b=6 then gives q_out=8'h2A.
- Random: 500 random ops against a behavioural golden model -> zero mismatches, checked on each done_out.
